spart_tx_ctrl: RTL and testbench

- Transmit sequencer for the SPART serial port; consumes the single-cycle baud tick from the baud-rate generator and serialises bytes onto txd.
- Format: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
- Each bit lasts OVERSAMPLE ticks.
- Double-buffered: a one-byte holding register plus a shift register allow back-to-back frames. Drives the generator's clear input to phase-align the first bit of a frame.

---
 rtl/spart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_spart_tx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_ctrl.sv
// SPART transmit sequencer: a holding register feeds a shift register that is
// serialised as start / DATA_BITS data (LSB first) / stop, OVERSAMPLE ticks per bit.
module spart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tbr,
    output logic       txd,
    output logic       busy,
    output logic       baud_clr
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_d;
    logic [TW-1:0]          tick_cnt, tick_d;
    logic [BW-1:0]          bit_cnt, bit_d;
    logic [DATA_BITS-1:0]   shifter, shift_d;
    logic [DATA_BITS-1:0]   hold, hold_d;
    logic                   tbr_d, txd_d, busy_d, clr_d;
    logic                   bit_end;

    assign bit_end = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            hold     <= '0;
            tbr      <= 1'b1;
            txd      <= 1'b1;
            busy     <= 1'b0;
            baud_clr <= 1'b0;
        end else begin
            state    <= state_d;
            tick_cnt <= tick_d;
            bit_cnt  <= bit_d;
            shifter  <= shift_d;
            hold     <= hold_d;
            tbr      <= tbr_d;
            txd      <= txd_d;
            busy     <= busy_d;
            baud_clr <= clr_d;
        end
    end

    always_comb begin
        state_d = state;
        tick_d  = tick_cnt;
        bit_d   = bit_cnt;
        shift_d = shifter;
        hold_d  = hold;
        tbr_d   = tbr;
        clr_d   = 1'b0;

        // A load while the holding register is full is dropped outright.
        if (tx_load && tbr) begin
            hold_d = tx_data[DATA_BITS-1:0];
            tbr_d  = 1'b0;
        end

        if (state != IDLE && baud_tick)
            tick_d = bit_end ? '0 : tick_cnt + TW'(1);

        case (state)
            IDLE: begin
                if (!tbr) begin
                    shift_d = hold;
                    tbr_d   = 1'b1;
                    clr_d   = 1'b1;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shifter >> 1;
                    bit_d   = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1))
                        state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next frame; the generator is already in phase.
                if (bit_end) begin
                    if (!tbr) begin
                        shift_d = hold;
                        tbr_d   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spart_tx_ctrl.sv
// Bench for spart_tx_ctrl: randomised loads against a byte-queue model; a negedge
// monitor decodes txd by baud-tick count and checks every bit cell, tbr, busy and baud_clr.
module tb_spart_tx_ctrl;

    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int FRAME_T = (DB + 2) * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tbr, txd, busy, baud_clr;

    spart_tx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_load(tx_load),
        .tx_data(tx_data), .tbr(tbr), .txd(txd), .busy(busy), .baud_clr(baud_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud generator model: tick every 4 cycles, reloaded by baud_clr.
    logic stall = 1'b0;
    initial begin : gen
        int bcnt;
        logic clr_prev;
        bcnt = 0;
        clr_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (clr_prev) bcnt = 0;
            else bcnt = (bcnt + 1) % 4;
            clr_prev = baud_clr;
            baud_tick = (bcnt == 3) && !stall;
        end
    end

    // Reference model: accepted-but-not-started bytes; a load is taken only when none wait.
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    bit  in_frame = 0;
    int  tk = 0;
    int  gap = 1;
    int  last_gap = 1;
    int  clr_cnt = 0;
    int  frames_done = 0;

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return b[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outs", {txd, tbr, busy, baud_clr}, 4'b1100);
            exp_q.delete();
            in_frame = 0;
            tk = 0;
            gap = 1;
        end else begin
            if (baud_clr) clr_cnt++;
            if (in_frame && tk == FRAME_T) begin
                in_frame = 0;
                frames_done++;
                gap = 0;
            end
            if (!in_frame && txd == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    cur = 8'hxx;
                end else begin
                    cur = exp_q.pop_front();
                end
                in_frame = 1;
                tk = 0;
                last_gap = gap;
                chk("baud_clr_start", baud_clr, gap != 0);
            end else begin
                chk("baud_clr_quiet", baud_clr, 0);
            end
            if (!in_frame) gap++;
            if (in_frame) chk("txd_bit", txd, exp_bit(cur, tk / OS));
            chk("busy", busy, in_frame);
            chk("tbr", tbr, exp_q.size() == 0);
            if (tx_load && exp_q.size() == 0) exp_q.push_back(tx_data);
            if (in_frame && baud_tick) tk++;
        end
    end

    task automatic load(input logic [7:0] b);
        @(posedge clk); #1;
        tx_load = 1'b1;
        tx_data = b;
        @(posedge clk); #1;
        tx_load = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < bound) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("idle_timeout", (exp_q.size() != 0 || in_frame), 0);
    endtask

    task automatic wait_tk(input int target, input int bound);
        int n;
        n = 0;
        while (!(in_frame && tk >= target) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("tk_timeout", n >= bound, 0);
    endtask

    initial begin : main
        int c0, f0, tkb, tka;
        // Reset and quiet idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (50) @(posedge clk);
        chk("idle_frames", frames_done, 0);

        // Single byte: latency checks
        c0 = clr_cnt;
        @(posedge clk); #1;
        tx_load = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1;
        tx_load = 1'b0;
        chk("tbr_fall", tbr, 0);
        chk("txd_before_start", txd, 1);
        @(posedge clk); #1;
        chk("txd_fall", txd, 0);
        chk("baud_clr_pulse", baud_clr, 1);
        wait_idle(2000);
        chk("single_clr_cnt", clr_cnt - c0, 1);
        chk("single_frames", frames_done, 1);

        // Back-to-back 0x00 then 0xFF
        c0 = clr_cnt; f0 = frames_done;
        load(8'h00);
        wait_tk(30, 500);
        load(8'hFF);
        wait_idle(3000);
        chk("b2b_clr_cnt", clr_cnt - c0, 1);
        chk("b2b_gap", last_gap, 0);
        chk("b2b_frames", frames_done - f0, 2);

        // Overrun: third load dropped
        f0 = frames_done;
        load(8'h11);
        repeat (5) @(posedge clk);
        load(8'h22);
        load(8'h33);
        wait_idle(3000);
        chk("overrun_frames", frames_done - f0, 2);

        // Tick stall mid-DATA
        f0 = frames_done;
        load(8'h96);
        wait_tk(3 * OS + 5, 2000);
        @(posedge clk); #1 stall = 1'b1;
        @(negedge clk); #1 tkb = tk;
        repeat (100) @(posedge clk);
        #1 tka = tk;
        chk("stall_frozen", tka, tkb);
        stall = 1'b0;
        wait_idle(2000);
        chk("stall_frames", frames_done - f0, 1);

        // Reset during data bit 3
        f0 = frames_done;
        load(8'h5A);
        wait_tk(4 * OS + 4, 2000);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_tbr", tbr, 1);
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        load(8'h3C);
        wait_idle(2000);
        chk("abort_frames", frames_done - f0, 1);

        // Random loads, random gaps and stalls
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 250)) @(posedge clk);
            if ($urandom_range(0, 4) == 0) begin
                #1 stall = 1'b1;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1 stall = 1'b0;
            end
            load(8'($urandom));
        end
        wait_idle(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
